// File: rtl/fir_pkg.sv
// Shared constants, state encoding and fixed coefficient table for the
// interpolate-by-2 serial FIR.
package fir_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned NTAPS      = 32;
  localparam int unsigned L          = 2;
  localparam int unsigned PHASE_TAPS = NTAPS / L;
  localparam int unsigned TAP_W      = $clog2(PHASE_TAPS);
  localparam int unsigned CNT_W      = TAP_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    MAC0,
    OUT0,
    MAC1,
    OUT1
  } state_t;

  // Prototype filter is the ramp h[k] = k, truncated to the datapath width.
  function automatic logic [DATA_W-1:0] coeff(input int unsigned k);
    return DATA_W'(k);
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Wrapping DATA_W multiply-accumulate; clr has priority over en.
module fir_mac_unit
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] prod_c;

  assign prod_c = DATA_W'(a * b);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_c;
    end
  end

endmodule

// File: rtl/fir_interp2_serial.sv
// Interpolate-by-2 polyphase FIR: one input sample yields a phase-0 and a
// phase-1 output, each computed by a single shared MAC over 16 taps.
module fir_interp2_serial
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] hist [PHASE_TAPS];
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mac_a_c;
  logic [DATA_W-1:0] mac_b_c;
  logic              accept_c;
  logic              mac_done_c;
  logic              mac_en_c;
  logic              mac_clr_c;
  logic              phase_c;

  assign accept_c   = (state == IDLE) && in_valid && in_ready;
  assign mac_done_c = (cnt == CNT_W'(PHASE_TAPS));
  assign phase_c    = (state == MAC1);
  assign mac_en_c   = ((state == MAC0) || (state == MAC1)) && !mac_done_c;
  assign mac_clr_c  = accept_c || ((state == OUT0) && out_ready);

  // Tap j of phase p pairs hist[j] with h[2j+p]; {j, p} is exactly 2j+p.
  assign mac_a_c = hist[cnt[TAP_W-1:0]];
  assign mac_b_c = coeff(32'({cnt[TAP_W-1:0], phase_c}));

  fir_mac_unit u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr_c),
    .en    (mac_en_c),
    .a     (mac_a_c),
    .b     (mac_b_c),
    .acc   (acc)
  );

  // Input history: newest sample at hist[0], shifted only on acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned j = 0; j < PHASE_TAPS; j++) begin
        hist[j] <= '0;
      end
    end else if (accept_c) begin
      for (int unsigned j = 1; j < PHASE_TAPS; j++) begin
        hist[j] <= hist[j-1];
      end
      hist[0] <= in_data;
    end
  end

  // Control FSM; the counter takes one extra cycle after the last tap so the
  // registered accumulator can be copied into out_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            state    <= MAC0;
            cnt      <= '0;
            in_ready <= 1'b0;
          end
        end
        MAC0, MAC1: begin
          if (mac_done_c) begin
            out_data  <= acc;
            out_valid <= 1'b1;
            state     <= (state == MAC0) ? OUT0 : OUT1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        OUT0: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt       <= '0;
            state     <= MAC1;
          end
        end
        OUT1: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp2_serial.sv
// Scoreboard bench: a zero-stuffed 32-tap convolution model predicts every
// output; a negedge monitor checks data, hold stability and latency.
module tb_fir_interp2_serial;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  fir_interp2_serial dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] u_q[$];
  logic [15:0] exp_q[$];

  int cyc = 0;
  int acc_edge = 0;
  int hs_edge = 0;
  int last_acc_edge = -1;
  int n_acc = 0;
  int phase = 0;
  bit prev_ov = 0;
  bit held_v = 0;
  logic [15:0] held_d;
  logic [15:0] last_p0, last_p1;
  bit b2b = 0;
  int rdy_mode = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout (cycle %0d)", name, cyc);
  endtask

  // y[m] = sum_k k * u[m-k] mod 2^16 over the zero-stuffed stream
  function automatic logic [15:0] y_at(input int m);
    logic [15:0] s = 16'h0;
    for (int k = 0; k < 32; k++) begin
      if (m - k >= 0) s = s + 16'(16'(k) * u_q[m-k]);
    end
    return s;
  endfunction

  function automatic void model_push(input logic [15:0] x);
    u_q.push_back(x);
    exp_q.push_back(y_at(u_q.size() - 1));
    u_q.push_back(16'h0);
    exp_q.push_back(y_at(u_q.size() - 1));
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      u_q.delete();
      exp_q.delete();
      phase   = 0;
      prev_ov = 0;
      held_v  = 0;
    end else begin
      if (in_valid && in_ready) begin
        model_push(in_data);
        acc_edge = cyc + 1;
        n_acc++;
        if (b2b && last_acc_edge >= 0)
          check("accept_interval_ok", int'((acc_edge - last_acc_edge) inside {[36:37]}), 1);
        last_acc_edge = acc_edge;
      end
      if (out_valid && !prev_ov) begin
        if (phase == 0) check("latency_phase0", cyc, acc_edge + 17);
        else            check("latency_phase1", cyc, hs_edge + 17);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", int'(out_data), -1);
        end else begin
          check($sformatf("out_data_phase%0d", phase), int'(out_data), int'(exp_q.pop_front()));
        end
        if (phase == 0) begin
          hs_edge = cyc + 1;
          last_p0 = out_data;
        end else begin
          last_p1 = out_data;
        end
        phase  = 1 - phase;
        held_v = 0;
      end else if (out_valid) begin
        if (held_v) check("hold_stable", int'(out_data), int'(held_d));
        held_v = 1;
        held_d = out_data;
      end else begin
        held_v = 0;
      end
      prev_ov = out_valid;
    end
  end

  // Downstream ready driver: 0 = stalled, 1 = always ready, 2 = random
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
    else               out_ready = (rdy_mode == 1);
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high
  task automatic send(input logic [15:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) timeout_fail("send");
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t = 0;
    in_valid = 1'b0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && in_ready) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) timeout_fail("drain");
    @(posedge clk); #1;
  endtask

  task automatic wait_ov(input bit level);
    int t = 0;
    @(negedge clk);
    while (out_valid !== level && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (out_valid !== level) timeout_fail("wait_out_valid");
  endtask

  initial begin
    int acc_before;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    @(posedge clk); #1 reset = 1'b1;

    // Impulse response
    send(16'd1);
    for (int i = 0; i < 15; i++) send(16'd0);
    drain();
    check("impulse_last_p0", int'(last_p0), 30);
    check("impulse_last_p1", int'(last_p1), 31);

    // Step: steady state 240 / 256
    for (int i = 0; i < 20; i++) send(16'd1);
    drain();
    check("step_p0", int'(last_p0), 240);
    check("step_p1", int'(last_p1), 256);

    // Modular wrap from a clean history
    do_reset();
    send(16'hFFFF);
    send(16'h0000);
    drain();
    check("wrap_p0", int'(last_p0), 16'hFFFE);
    check("wrap_p1", int'(last_p1), 16'hFFFD);

    // Backpressure in OUT0 with an in_valid pulse that must be ignored
    rdy_mode = 0;
    @(posedge clk); #1;
    send(16'($urandom));
    in_valid = 1'b0;
    wait_ov(1'b1);
    acc_before = n_acc;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = (i == 3);
      in_data  = 16'hBEEF;
      @(negedge clk);
      check("bp_in_ready_low", int'(in_ready), 0);
      check("bp_out_valid_high", int'(out_valid), 1);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    check("bp_no_accept", n_acc, acc_before);
    rdy_mode = 1;
    drain();

    // Reset in the middle of MAC1 discards history and pending output
    do_reset();
    for (int i = 0; i < 4; i++) send(16'($urandom));
    drain();
    send(16'($urandom));
    in_valid = 1'b0;
    wait_ov(1'b1);
    wait_ov(1'b0);
    repeat (7) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_in_ready", int'(in_ready), 1);
    check("midreset_out_data", int'(out_data), 0);
    @(posedge clk); #1 reset = 1'b1;
    send(16'd1);
    for (int i = 0; i < 15; i++) send(16'd0);
    drain();
    check("midreset_impulse_p0", int'(last_p0), 30);
    check("midreset_impulse_p1", int'(last_p1), 31);

    // Back-to-back with in_valid held high
    last_acc_edge = -1;
    b2b = 1;
    for (int i = 0; i < 8; i++) send(16'($urandom));
    drain();
    b2b = 0;

    // Random data with random backpressure and idle gaps
    rdy_mode = 2;
    for (int i = 0; i < 10; i++) begin
      send(16'($urandom));
      in_valid = 1'b0;
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
    end
    drain();
    rdy_mode = 1;

    check("queue_empty_at_end", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
